// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and constants for the AVR serial path
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int DATA_BITS       = 8;
   localparam int DEF_CLK_PER_BIT = 100;  // 50 MHz / 500 kbaud

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - first-word-fall-through FIFO with registered full/empty flags
module byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             wr,
   input  logic             rd,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
   logic [AW:0]      r_count, w_count_n;
   logic             r_full, r_empty;
   logic             w_do_wr, w_do_rd;

   // a write while full is dropped even if a pop happens in the same cycle
   assign w_do_wr = wr && !r_full;
   assign w_do_rd = rd && !r_empty;

   always_comb begin
      w_count_n = r_count;
      if (w_do_wr && !w_do_rd)
         w_count_n = r_count + CNT_ONE;
      else if (!w_do_wr && w_do_rd)
         w_count_n = r_count - CNT_ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_n;
         r_full  <= (w_count_n == CNT_FULL);
         r_empty <= (w_count_n == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_wr) r_mem[r_wr_ptr] <= din;
   end

   assign dout  = r_mem[r_rd_ptr];
   assign full  = r_full;
   assign empty = r_empty;

endmodule

// File: rtl/avr_serial_tx.sv
// rtl/avr_serial_tx.sv - 8N1 UART transmitter to the AVR with busy flow control
module avr_serial_tx
   import serial_pkg::*;
#(
   parameter int CLK_PER_BIT = DEF_CLK_PER_BIT,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data,
   input  logic       new_data,
   output logic       full,
   input  logic       block,
   output logic       tx,
   output logic       busy
);

   localparam int CW = $clog2(CLK_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] CYC_LAST = CW'(CLK_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   tx_state_t            r_state, w_state_n;
   logic [DATA_BITS-1:0] r_shift, w_shift_n;
   logic [BW-1:0]        r_bit, w_bit_n;
   logic [CW-1:0]        r_cyc, w_cyc_n;
   logic                 r_tx, w_tx_n;
   logic                 r_blk_meta, r_blk_s;
   logic                 w_pop, w_cyc_last;
   logic [7:0]           w_fifo_dout;
   logic                 w_fifo_empty, w_fifo_full;

   byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (data),
      .wr    (new_data),
      .rd    (w_pop),
      .dout  (w_fifo_dout),
      .full  (w_fifo_full),
      .empty (w_fifo_empty)
   );

   // synchroniser resets to "blocked" so no frame starts until it has settled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blk_meta <= 1'b1;
         r_blk_s    <= 1'b1;
      end else begin
         r_blk_meta <= block;
         r_blk_s    <= r_blk_meta;
      end
   end

   assign w_cyc_last = (r_cyc == CYC_LAST);

   always_comb begin
      w_state_n = r_state;
      w_shift_n = r_shift;
      w_bit_n   = r_bit;
      w_cyc_n   = r_cyc;
      w_pop     = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_fifo_empty && !r_blk_s) begin
               w_pop     = 1'b1;
               w_shift_n = w_fifo_dout;
               w_bit_n   = '0;
               w_cyc_n   = '0;
               w_state_n = START;
            end
         end
         START: begin
            if (w_cyc_last) begin
               w_cyc_n   = '0;
               w_bit_n   = '0;
               w_state_n = DATA;
            end else begin
               w_cyc_n = r_cyc + CW'(1);
            end
         end
         DATA: begin
            if (w_cyc_last) begin
               w_cyc_n = '0;
               if (r_bit == BIT_LAST) begin
                  w_state_n = STOP;
               end else begin
                  w_shift_n = r_shift >> 1;
                  w_bit_n   = r_bit + BW'(1);
               end
            end else begin
               w_cyc_n = r_cyc + CW'(1);
            end
         end
         STOP: begin
            if (w_cyc_last) begin
               w_cyc_n   = '0;
               w_state_n = IDLE;
            end else begin
               w_cyc_n = r_cyc + CW'(1);
            end
         end
         default: w_state_n = IDLE;
      endcase

      // tx is registered from the next state so the line changes on the same edge as the FSM
      case (w_state_n)
         START:   w_tx_n = 1'b0;
         DATA:    w_tx_n = w_shift_n[0];
         default: w_tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_bit   <= '0;
         r_cyc   <= '0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_n;
         r_shift <= w_shift_n;
         r_bit   <= w_bit_n;
         r_cyc   <= w_cyc_n;
         r_tx    <= w_tx_n;
      end
   end

   assign tx   = r_tx;
   assign full = w_fifo_full;
   assign busy = (r_state != IDLE) || !w_fifo_empty;

endmodule

// File: tb/tb_avr_serial_tx.sv
// tb/tb_avr_serial_tx.sv - directed-vector bench for avr_serial_tx
module tb_avr_serial_tx;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] data = 8'h00;
   logic       new_data = 1'b0;
   logic       block = 1'b0;
   logic       full, tx, busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   avr_serial_tx #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .data     (data),
      .new_data (new_data),
      .full     (full),
      .block    (block),
      .tx       (tx),
      .busy     (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // expected line level in cycle i of a frame: start, 8 data bits LSB first, stop
   function automatic logic fbit(input logic [7:0] b, input int i);
      int k;
      k = i / CPB;
      if (k == 0) return 1'b0;
      else if (k <= 8) return b[k-1];
      else return 1'b1;
   endfunction

   task automatic frame_span(input logic [7:0] b, input int from, input int to);
      for (int i = from; i < to; i++) begin
         chk($sformatf("frame_%02h_cyc%0d", b, i), {31'd0, tx}, {31'd0, fbit(b, i)});
         @(negedge clk);
      end
   endtask

   task automatic gap(input logic exp_busy);
      chk("gap_tx", {31'd0, tx}, 32'd1);
      chk("gap_busy", {31'd0, busy}, {31'd0, exp_busy});
   endtask

   task automatic put(input logic [7:0] b);
      data     = b;
      new_data = 1'b1;
      @(negedge clk);
      new_data = 1'b0;
   endtask

   initial begin
      // asynchronous reset, checked before any clock edge
      #1 rst_n = 1'b0;
      #2;
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_full", {31'd0, full}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // single byte: pop one edge after the write, start bit right after the pop
      put(8'hA5);
      chk("t1_busy_after_wr", {31'd0, busy}, 32'd1);
      chk("t1_tx_before_pop", {31'd0, tx}, 32'd1);
      @(negedge clk);
      frame_span(8'hA5, 0, 40);
      gap(1'b0);
      repeat (3) @(negedge clk);

      // burst of five writes: first pop frees a slot, so all five land and full rises
      new_data = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         data = 8'(i);
         @(negedge clk);
      end
      new_data = 1'b0;
      chk("t2_full_after_burst", {31'd0, full}, 32'd1);
      frame_span(8'h01, 3, 40);
      gap(1'b1);
      chk("t6_full_at_gap", {31'd0, full}, 32'd1);
      // write while full coinciding with the pop: dropped, count falls by one
      data     = 8'hEE;
      new_data = 1'b1;
      @(negedge clk);
      new_data = 1'b0;
      chk("t6_full_after_drop", {31'd0, full}, 32'd0);
      frame_span(8'h02, 0, 40);
      gap(1'b1);
      @(negedge clk);
      frame_span(8'h03, 0, 40);
      gap(1'b1);
      @(negedge clk);
      frame_span(8'h04, 0, 40);
      gap(1'b1);
      @(negedge clk);
      frame_span(8'h05, 0, 40);
      gap(1'b0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("t6_no_extra_frame", {31'd0, tx}, 32'd1);
      end

      // block held: byte waits; start bit three edges after release
      block = 1'b1;
      repeat (3) @(negedge clk);
      put(8'h3C);
      for (int i = 0; i < 6; i++) begin
         chk("t3_hold_tx", {31'd0, tx}, 32'd1);
         chk("t3_hold_busy", {31'd0, busy}, 32'd1);
         @(negedge clk);
      end
      block = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t3_tx_before_pop", {31'd0, tx}, 32'd1);
      @(negedge clk);
      frame_span(8'h3C, 0, 40);
      gap(1'b0);
      repeat (2) @(negedge clk);

      // block rises mid-frame: 0xFF completes, queued 0x00 waits for release
      data     = 8'hFF;
      new_data = 1'b1;
      @(negedge clk);
      data = 8'h00;
      @(negedge clk);
      new_data = 1'b0;
      frame_span(8'hFF, 0, 12);
      block = 1'b1;
      frame_span(8'hFF, 12, 40);
      gap(1'b1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("t4_held_tx", {31'd0, tx}, 32'd1);
      end
      block = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t4_tx_before_pop", {31'd0, tx}, 32'd1);
      @(negedge clk);
      frame_span(8'h00, 0, 40);
      gap(1'b0);
      repeat (2) @(negedge clk);

      // reset during data bit 3 of 0x55 aborts the frame, then 0x81 goes out cleanly
      put(8'h55);
      @(negedge clk);
      frame_span(8'h55, 0, 18);
      chk("t5_bit3_low", {31'd0, tx}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_tx", {31'd0, tx}, 32'd1);
      chk("t5_rst_busy", {31'd0, busy}, 32'd0);
      chk("t5_rst_full", {31'd0, full}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("t5_idle_after_rst", {31'd0, tx}, 32'd1);
      put(8'h81);
      @(negedge clk);
      frame_span(8'h81, 0, 40);
      gap(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/avr_serial_tx.md
Name: avr_serial_tx

Overview:
UART transmitter driving the FPGA-to-AVR serial line (`avr_rx` pin at top level).
- Accepts bytes from fabric logic into a small FIFO.
- Serialises them as 8N1 frames, LSB first.
- Honours the AVR's `avr_rx_busy` flow-control signal.
- Sits beside the top-level module; replaces the high-z tie-off on `avr_rx` when serial output is enabled.

Parameters:
- CLK_PER_BIT, 100, clock cycles per bit period (50 MHz / 500 kbaud); legal range ≥ 2.
- FIFO_DEPTH, 4, number of byte entries in the input FIFO; power of two, ≥ 2.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- data  input  8  byte to transmit.
- new_data  input  1  write strobe; `data` is accepted on a rising edge where new_data=1 and full=0.
- full  output  1  FIFO holds FIFO_DEPTH entries; writes are ignored while high.
- block  input  1  AVR receive buffer full (connect to `avr_rx_busy`); asynchronous to clk.
- tx  output  1  serial line to AVR, idle high.
- busy  output  1  high while a frame is in progress or the FIFO is non-empty.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - tx=1, busy=0, full=0.
  - FIFO emptied, FSM=IDLE, bit counter and cycle counter = 0.
  - Reset asserted mid-frame aborts the frame immediately; tx returns high with no glitch low.
- block synchroniser:
  - Two-flop synchroniser feeding block_s.
  - Both flops reset to 1, so a start is held off until 2 cycles after reset release.
- FIFO:
  - Write when new_data && !full; pop only by the FSM.
  - A write and a pop in the same cycle are both performed; count is unchanged.
  - A write while full is dropped silently. There is no pass-through: a write while full is not rescued by a same-cycle pop.
  - full and the empty flag are registered from count.
- FSM states:
  - IDLE:
    - tx=1.
    - If FIFO non-empty and block_s=0: pop the head into shift register, counters cleared, go to START.
    - Otherwise stay in IDLE.
  - START: tx=0 for CLK_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA:
    - tx=shift[0] for CLK_PER_BIT cycles, then shift right and bit_idx++.
    - After bit_idx=7 completes, go to STOP.
  - STOP: tx=1 for CLK_PER_BIT cycles, then go to IDLE.
- block handling:
  - Sampled only in IDLE.
  - Assertion during START/DATA/STOP does not interrupt the current frame.
  - The next frame is held until block_s=0.
- Timing:
  - Frame length is exactly 10×CLK_PER_BIT cycles.
  - Minimum gap between back-to-back frames is 1 cycle (the IDLE visit), so the frame period is 10×CLK_PER_BIT+1.
- Latency: write accepted at edge E0 into an empty FIFO with block_s=0:
  - FIFO non-empty visible after E0.
  - FSM pops at E1.
  - tx falls after E1 (start bit begins in the cycle following E1).
- tx is driven from a register; no combinational path from inputs to tx.
- busy = (state≠IDLE) || FIFO non-empty; registered-equivalent, no glitches.
- The cycle counter wraps at CLK_PER_BIT−1 and must be sized $clog2(CLK_PER_BIT).
- Counter widths for FIFO pointers: $clog2(FIFO_DEPTH). count is one bit wider.

Decomposition:
- Shared package `serial_pkg`:
  - FSM state enum: IDLE, START, DATA, STOP.
  - Constants: DATA_BITS=8, default CLK_PER_BIT for 50 MHz/500 kbaud.
- One sub-module, `byte_fifo`, which is reusable for the receive path:
  - Parameters: WIDTH, DEPTH.
  - Ports: clk, rst_n, din, wr, rd, dout, full, empty.
  - Registered flags, first-word-fall-through dout.
- Synchroniser stays inline.

Test Plan (CLK_PER_BIT=4, FIFO_DEPTH=4):
- Single byte 0xA5, block=0 → tx low 1 cycle after the pop edge, then 4-cycle bits 0,1,0,1,0,0,1,0,1,1; busy deasserts the cycle after stop ends; total frame 40 cycles.
- Burst 0x01,0x02,0x03,0x04,0x05 on consecutive cycles → full rises after 4th write, 5th write dropped (or accepted if a pop has already occurred; check against count); frames separated by exactly 1 idle cycle (period 41).
- block=1 held, write 0x3C → tx stays 1 and busy=1; release block → start bit begins 3 cycles after release (2 sync + pop edge).
- block asserted during DATA of 0xFF → frame completes intact; the next queued byte 0x00 waits until block deasserts.
- rst_n pulsed low during bit 3 of 0x55 → tx=1 asynchronously, busy=0, full=0; after release a new write of 0x81 transmits correctly.
- Write while full concurrent with pop → write dropped, count decrements by 1, no corruption of queued data order.
